three_vote_core: RTL and testbench



---
 rtl/three_vote_core.sv | 80 ++++++++
 tb/tb_three_vote_core.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/three_vote_core.sv
// three_vote_core: 2-of-3 majority voter for triple-redundant control bits.
//
// Optional feature macro: THREE_VOTE_CNT_EN
//   defined   -> per-input saturating dissent counters and cnt_a/cnt_b/cnt_c ports
//   undefined -> counters and their ports are absent
//
// Ports:
//   clk          rising-edge system clock
//   rst          synchronous, active-high reset
//   a, b, c      replica channels
//   r            combinational majority of a, b, c (independent of clk/rst)
//   r_q          registered r                     (reset 0)
//   unanimous_q  registered a == b == c           (reset 1)
//   dissent_q    registered one-hot dissenter {c,b,a}, 000 when unanimous (reset 000)
//   cnt_a/b/c    saturating dissent counters, CNT_W bits each (macro only, reset 0)
module three_vote_core #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             r,
  output logic             r_q,
  output logic             unanimous_q,
  output logic [2:0]       dissent_q
`ifdef THREE_VOTE_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c
`endif
);

  logic [2:0] dissent;
  logic       unanimous;

  // Vote and dissent decode; at most one input can differ from the majority.
  always_comb begin
    r          = (a & b) | (a & c) | (b & c);
    dissent    = {c ^ r, b ^ r, a ^ r};
    unanimous  = (dissent == 3'b000);
  end

  // Registered monitor outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= 1'b0;
      unanimous_q <= 1'b1;
      dissent_q   <= 3'b000;
    end else begin
      r_q         <= r;
      unanimous_q <= unanimous;
      dissent_q   <= dissent;
    end
  end

`ifdef THREE_VOTE_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [3];

  // Per-input dissent counters; hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (dissent[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  assign cnt_a = cnt[0];
  assign cnt_b = cnt[1];
  assign cnt_c = cnt[2];
`endif

endmodule

// File: tb/tb_three_vote_core.sv
// Directed self-checking bench for three_vote_core. Counter checks are built
// only when THREE_VOTE_CNT_EN is defined; a second instance with CNT_W=2
// exercises saturation.
module tb_three_vote_core;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0;
  logic r, r_q, unanimous_q;
  logic [2:0] dissent_q;

  int checks = 0;
  int failures = 0;

`ifdef THREE_VOTE_CNT_EN
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic r2, r2_q, unanimous2_q;
  logic [2:0] dissent2_q;
  logic [1:0] cnt2_a, cnt2_b, cnt2_c;
`endif

  three_vote_core #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .r(r), .r_q(r_q), .unanimous_q(unanimous_q), .dissent_q(dissent_q)
`ifdef THREE_VOTE_CNT_EN
    , .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c)
`endif
  );

`ifdef THREE_VOTE_CNT_EN
  three_vote_core #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .r(r2), .r_q(r2_q), .unanimous_q(unanimous2_q), .dissent_q(dissent2_q),
    .cnt_a(cnt2_a), .cnt_b(cnt2_b), .cnt_c(cnt2_c)
  );
`endif

  // Clock runs only once enabled, so the first phase is purely combinational.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic rq, input logic un, input logic [2:0] ds);
    chk({tag, ".r_q"}, 16'(r_q), 16'(rq));
    chk({tag, ".unanimous_q"}, 16'(unanimous_q), 16'(un));
    chk({tag, ".dissent_q"}, 16'(dissent_q), 16'(ds));
  endtask

  task automatic chk_cnt(input string tag, input int ea, input int eb, input int ec);
`ifdef THREE_VOTE_CNT_EN
    chk({tag, ".cnt_a"}, 16'(cnt_a), 16'(ea));
    chk({tag, ".cnt_b"}, 16'(cnt_b), 16'(eb));
    chk({tag, ".cnt_c"}, 16'(cnt_c), 16'(ec));
`else
    if (ea + eb + ec < 0) $display("unreachable %s", tag);
`endif
  endtask

  logic [7:0] r_table;
  logic [2:0] v;

  initial begin
    // Combinational truth table, no clock; expected r for 000..111 is 0,0,0,1,0,1,1,1.
    r_table = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a, b, c} = v;
      #10;
      chk($sformatf("r_comb_%0d", i), 16'(r), 16'(r_table[i]));
    end

    // Reset then a=1,b=1,c=0.
    clk_en = 1'b1;
    rst = 1'b1; {a, b, c} = 3'b000;
    tick();
    chk_regs("after_rst", 1'b0, 1'b1, 3'b000);
    chk_cnt("after_rst", 0, 0, 0);
    rst = 1'b0; {a, b, c} = 3'b110;
    #1 chk("r_110", 16'(r), 16'd1);
    tick();
    chk_regs("edge_110", 1'b1, 1'b0, 3'b100);

    // Clear, then b is the sole dissenter for three edges.
    rst = 1'b1;
    tick();
    rst = 1'b0; {a, b, c} = 3'b010;
    tick(); tick(); tick();
    chk_regs("b_dissent", 1'b0, 1'b0, 3'b010);
    chk_cnt("b_dissent", 0, 3, 0);
`ifdef THREE_VOTE_CNT_EN
    chk("w2_b_dissent.cnt_b", 16'(cnt2_b), 16'd3);
`endif

    // Clear, then c dissents for six edges; the 2-bit counter stops at 3.
    rst = 1'b1;
    tick();
    rst = 1'b0; {a, b, c} = 3'b110;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_cnt($sformatf("c_dissent_%0d", k), 0, 0, k);
`ifdef THREE_VOTE_CNT_EN
      chk($sformatf("w2_c_sat_%0d", k), 16'(cnt2_c), 16'((k > 3) ? 3 : k));
`endif
    end
    chk_regs("c_dissent", 1'b1, 1'b0, 3'b100);

    // Reset with dissent still active; r keeps tracking inputs during reset.
    rst = 1'b1;
    #1 chk("r_in_rst_110", 16'(r), 16'd1);
    tick();
    chk_regs("mid_rst", 1'b0, 1'b1, 3'b000);
    chk_cnt("mid_rst", 0, 0, 0);
`ifdef THREE_VOTE_CNT_EN
    chk("w2_mid_rst.cnt_c", 16'(cnt2_c), 16'd0);
`endif
    {a, b, c} = 3'b101;
    #1 chk("r_in_rst_101", 16'(r), 16'd1);
    {a, b, c} = 3'b001;
    #1 chk("r_in_rst_001", 16'(r), 16'd0);
    tick();
    chk_regs("held_rst", 1'b0, 1'b1, 3'b000);

    // Unanimous ones, then c-only high, then a dissenting low.
    rst = 1'b0; {a, b, c} = 3'b111;
    tick();
    chk_regs("unan_111", 1'b1, 1'b1, 3'b000);
    {a, b, c} = 3'b001;
    tick();
    chk_regs("c_high", 1'b0, 1'b0, 3'b100);
    {a, b, c} = 3'b011;
    tick();
    chk_regs("a_low", 1'b1, 1'b0, 3'b001);
    chk_cnt("a_low", 1, 0, 1);
    {a, b, c} = 3'b000;
    tick();
    chk_regs("unan_000", 1'b0, 1'b1, 3'b000);
    chk_cnt("unan_000", 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
